// File: rtl/dense_param_updater_pkg.sv
// Shared types and default parameters for the dense-layer momentum-SGD sequencer.
package dense_param_updater_pkg;

    // Training fixed-point formats and layer geometry defaults.
    localparam int unsigned N_LEN         = 16;  // weight / velocity lane width
    localparam int unsigned N_LEN_W       = 32;  // gradient lane width
    localparam int unsigned HID_DIM       = 64;
    localparam int unsigned CHAR_NUM      = 16;
    localparam int unsigned DEF_DATA_N    = 8;
    localparam int unsigned DEF_DEPTH     = HID_DIM * CHAR_NUM / DEF_DATA_N;

    // Optimiser defaults: momentum = 1 - 2^-MOM_SHIFT, lr = 2^-LR_SHIFT.
    localparam int unsigned DEF_MOM_SHIFT = 3;
    localparam int unsigned DEF_LR_SHIFT  = 4;

    typedef enum logic [2:0] {
        IDLE,
        UPD,
        ZERO,
        DONE_U,
        DONE_Z
    } upd_state_e;

endpackage

// File: rtl/dense_optim_lane.sv
// One lane of the momentum-SGD update: v' = v - v*2^-M - g*2^-L, w' = w + v',
// both saturated to DATA_WIDTH. Purely combinational.
// Intermediate math is GRAD_WIDTH+2 bits wide, so GRAD_WIDTH >= DATA_WIDTH is assumed.
module dense_optim_lane #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned GRAD_WIDTH = 32,
    parameter int unsigned MOM_SHIFT  = 3,
    parameter int unsigned LR_SHIFT   = 4
) (
    input  logic [DATA_WIDTH-1:0] w_i,
    input  logic [DATA_WIDTH-1:0] v_i,
    input  logic [GRAD_WIDTH-1:0] g_i,
    output logic [DATA_WIDTH-1:0] v_o,
    output logic [DATA_WIDTH-1:0] w_o
);

    localparam int unsigned CW = GRAD_WIDTH + 2;

    logic signed [CW-1:0] w_ext;
    logic signed [CW-1:0] v_ext;
    logic signed [CW-1:0] g_ext;
    logic signed [CW-1:0] v_sum;
    logic signed [CW-1:0] vs_ext;
    logic signed [CW-1:0] w_sum;
    logic [DATA_WIDTH-1:0] v_sat;

    // Clamp a wide signed value into DATA_WIDTH: in range when all bits above
    // the destination sign bit agree with it.
    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [CW-1:0] x);
        logic [CW-DATA_WIDTH:0] hi;
        hi = x[CW-1:DATA_WIDTH-1];
        if ((hi == '0) || (hi == '1)) begin
            return x[DATA_WIDTH-1:0];
        end else if (x[CW-1]) begin
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    endfunction

    assign w_ext  = {{(CW-DATA_WIDTH){w_i[DATA_WIDTH-1]}}, w_i};
    assign v_ext  = {{(CW-DATA_WIDTH){v_i[DATA_WIDTH-1]}}, v_i};
    assign g_ext  = {{2{g_i[GRAD_WIDTH-1]}}, g_i};

    // Velocity then weight, each with its own saturation stage.
    always_comb begin
        v_sum  = v_ext - (v_ext >>> MOM_SHIFT) - (g_ext >>> LR_SHIFT);
        v_sat  = sat(v_sum);
        vs_ext = {{(CW-DATA_WIDTH){v_sat[DATA_WIDTH-1]}}, v_sat};
        w_sum  = w_ext + vs_ext;
    end

    assign v_o = v_sat;
    assign w_o = sat(w_sum);

endmodule

// File: rtl/dense_param_updater.sv
// Momentum-SGD sequencer: sweeps weight/velocity/gradient RAMs on update and
// clears the gradient RAM on zero_grad. Read issue -> RAM latency -> registered
// write gives a fixed 3-cycle read-to-write pipeline at one word per cycle.
module dense_param_updater
    import dense_param_updater_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_N     = DEF_DATA_N,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned DATA_WIDTH = N_LEN,
    parameter int unsigned GRAD_WIDTH = N_LEN_W,
    parameter int unsigned MOM_SHIFT  = DEF_MOM_SHIFT,
    parameter int unsigned LR_SHIFT   = DEF_LR_SHIFT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         update,
    input  logic                         zero_grad,
    output logic                         valid_update,
    output logic                         valid_zero_grad,
    output logic [ADDR_WIDTH-1:0]        raddr,
    input  logic [DATA_N*DATA_WIDTH-1:0] w_rdata,
    input  logic [DATA_N*DATA_WIDTH-1:0] v_rdata,
    input  logic [DATA_N*GRAD_WIDTH-1:0] grad_rdata,
    output logic [ADDR_WIDTH-1:0]        waddr,
    output logic                         w_load,
    output logic                         v_load,
    output logic                         grad_load,
    output logic [DATA_N*DATA_WIDTH-1:0] w_wdata,
    output logic [DATA_N*DATA_WIDTH-1:0] v_wdata,
    output logic [DATA_N*GRAD_WIDTH-1:0] grad_wdata
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    upd_state_e                  state_q;
    logic [ADDR_WIDTH-1:0]       cnt_q;
    logic                        issue_done_q;
    logic [ADDR_WIDTH-1:0]       raddr_q;
    logic                        s1_vld_q;   // read issued last edge, RAM data arrives now
    logic                        s2_vld_q;   // RAM data valid on *_rdata this cycle
    logic [ADDR_WIDTH-1:0]       s2_addr_q;
    logic [ADDR_WIDTH-1:0]       waddr_q;
    logic                        w_load_q;
    logic                        v_load_q;
    logic                        grad_load_q;
    logic [DATA_N*DATA_WIDTH-1:0] w_wdata_q;
    logic [DATA_N*DATA_WIDTH-1:0] v_wdata_q;
    logic                        valid_update_q;
    logic                        valid_zero_q;

    logic [DATA_N*DATA_WIDTH-1:0] w_new_d;
    logic [DATA_N*DATA_WIDTH-1:0] v_new_d;

    for (genvar i = 0; i < DATA_N; i++) begin : g_lane
        dense_optim_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .GRAD_WIDTH (GRAD_WIDTH),
            .MOM_SHIFT  (MOM_SHIFT),
            .LR_SHIFT   (LR_SHIFT)
        ) u_lane (
            .w_i (w_rdata[i*DATA_WIDTH +: DATA_WIDTH]),
            .v_i (v_rdata[i*DATA_WIDTH +: DATA_WIDTH]),
            .g_i (grad_rdata[i*GRAD_WIDTH +: GRAD_WIDTH]),
            .v_o (v_new_d[i*DATA_WIDTH +: DATA_WIDTH]),
            .w_o (w_new_d[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // FSM, sweep counter, address pipeline and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            issue_done_q   <= 1'b0;
            raddr_q        <= '0;
            s1_vld_q       <= 1'b0;
            s2_vld_q       <= 1'b0;
            s2_addr_q      <= '0;
            waddr_q        <= '0;
            w_load_q       <= 1'b0;
            v_load_q       <= 1'b0;
            grad_load_q    <= 1'b0;
            w_wdata_q      <= '0;
            v_wdata_q      <= '0;
            valid_update_q <= 1'b0;
            valid_zero_q   <= 1'b0;
        end else begin
            // Pipeline advance; stages only fill while an update is issuing.
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= s1_vld_q;
            if (s1_vld_q) begin
                s2_addr_q <= raddr_q;
            end
            w_load_q    <= 1'b0;
            v_load_q    <= 1'b0;
            grad_load_q <= 1'b0;
            if (s2_vld_q) begin
                w_load_q  <= 1'b1;
                v_load_q  <= 1'b1;
                waddr_q   <= s2_addr_q;
                w_wdata_q <= w_new_d;
                v_wdata_q <= v_new_d;
            end

            case (state_q)
                IDLE, DONE_U, DONE_Z: begin
                    if (update) begin
                        state_q        <= UPD;
                        cnt_q          <= '0;
                        issue_done_q   <= 1'b0;
                        valid_update_q <= 1'b0;
                        valid_zero_q   <= 1'b0;
                    end else if (zero_grad) begin
                        state_q        <= ZERO;
                        cnt_q          <= '0;
                        issue_done_q   <= 1'b0;
                        valid_update_q <= 1'b0;
                        valid_zero_q   <= 1'b0;
                    end
                end
                UPD: begin
                    if (!issue_done_q) begin
                        raddr_q  <= cnt_q;
                        s1_vld_q <= 1'b1;
                        if (cnt_q == LAST) begin
                            issue_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    // Last write is on the bus this cycle: sweep complete at this edge.
                    if (w_load_q && (waddr_q == LAST)) begin
                        state_q        <= DONE_U;
                        valid_update_q <= 1'b1;
                    end
                end
                ZERO: begin
                    if (!issue_done_q) begin
                        grad_load_q <= 1'b1;
                        waddr_q     <= cnt_q;
                        if (cnt_q == LAST) begin
                            issue_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    if (grad_load_q && (waddr_q == LAST)) begin
                        state_q      <= DONE_Z;
                        valid_zero_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign valid_update    = valid_update_q;
    assign valid_zero_grad = valid_zero_q;
    assign raddr           = raddr_q;
    assign waddr           = waddr_q;
    assign w_load          = w_load_q;
    assign v_load          = v_load_q;
    assign grad_load       = grad_load_q;
    assign w_wdata         = w_wdata_q;
    assign v_wdata         = v_wdata_q;
    assign grad_wdata      = '0;

endmodule

// File: tb/tb_dense_param_updater.sv
// Directed bench for dense_param_updater with behavioural 1-cycle-latency RAMs.
module tb_dense_param_updater;

    localparam int AW    = 10;
    localparam int DN    = 4;
    localparam int DEP   = 8;
    localparam int DW    = 16;
    localparam int GW    = 32;
    localparam int NV    = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic update;
    logic zero_grad;
    logic valid_update;
    logic valid_zero_grad;
    logic [AW-1:0] raddr;
    logic [AW-1:0] waddr;
    logic [DN*DW-1:0] w_rdata, v_rdata, w_wdata, v_wdata;
    logic [DN*GW-1:0] grad_rdata, grad_wdata;
    logic w_load, v_load, grad_load;

    logic [DN*DW-1:0] w_mem [DEP];
    logic [DN*DW-1:0] v_mem [DEP];
    logic [DN*GW-1:0] g_mem [DEP];

    int checks = 0;
    int errors = 0;
    int wv_writes = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    dense_param_updater #(
        .ADDR_WIDTH (AW),
        .DATA_N     (DN),
        .DEPTH      (DEP),
        .DATA_WIDTH (DW),
        .GRAD_WIDTH (GW),
        .MOM_SHIFT  (3),
        .LR_SHIFT   (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .update          (update),
        .zero_grad       (zero_grad),
        .valid_update    (valid_update),
        .valid_zero_grad (valid_zero_grad),
        .raddr           (raddr),
        .w_rdata         (w_rdata),
        .v_rdata         (v_rdata),
        .grad_rdata      (grad_rdata),
        .waddr           (waddr),
        .w_load          (w_load),
        .v_load          (v_load),
        .grad_load       (grad_load),
        .w_wdata         (w_wdata),
        .v_wdata         (v_wdata),
        .grad_wdata      (grad_wdata)
    );

    // RAM models: registered read, write on load.
    always @(posedge clk) begin
        w_rdata    <= w_mem[raddr[2:0]];
        v_rdata    <= v_mem[raddr[2:0]];
        grad_rdata <= g_mem[raddr[2:0]];
        if (w_load) w_mem[waddr[2:0]] <= w_wdata;
        if (v_load) v_mem[waddr[2:0]] <= v_wdata;
        if (grad_load) g_mem[waddr[2:0]] <= grad_wdata;
        if (w_load || v_load) wv_writes <= wv_writes + 1;
        if (grad_load && (w_load || v_load)) overlap <= overlap + 1;
    end

    typedef struct {
        logic [DW-1:0] w;
        logic [DW-1:0] v;
        logic [GW-1:0] g;
        logic [DW-1:0] ev;
        logic [DW-1:0] ew;
    } vec_t;

    vec_t vt [NV];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, " w_load"}, 128'(w_load), 128'd0);
        chk({nm, " v_load"}, 128'(v_load), 128'd0);
        chk({nm, " grad_load"}, 128'(grad_load), 128'd0);
    endtask

    // Load vector table into RAM: lane i of word a holds vector (a+i) % NV.
    task automatic fill_rams();
        int unsigned k;
        for (int a = 0; a < DEP; a++) begin
            for (int i = 0; i < DN; i++) begin
                k = (a + i) % NV;
                w_mem[a][i*DW +: DW] = vt[k].w;
                v_mem[a][i*DW +: DW] = vt[k].v;
                g_mem[a][i*GW +: GW] = vt[k].g;
            end
        end
    endtask

    // Update sweep with per-cycle timing checks; start is edge 0.
    task automatic run_update(input string nm);
        @(negedge clk);
        update = 1'b1;
        @(posedge clk);
        #1;
        update = 1'b0;
        for (int n = 1; n <= DEP + 3; n++) begin
            @(posedge clk);
            #1;
            if (n <= DEP) chk({nm, " raddr"}, 128'(raddr), 128'(n - 1));
            chk({nm, " w_load"}, 128'(w_load), 128'((n >= 3) && (n <= DEP + 2)));
            if ((n >= 3) && (n <= DEP + 2)) chk({nm, " waddr"}, 128'(waddr), 128'(n - 3));
            chk({nm, " grad_load"}, 128'(grad_load), 128'd0);
            chk({nm, " valid_update"}, 128'(valid_update), 128'(n == DEP + 3));
        end
        chk({nm, " raddr hold"}, 128'(raddr), 128'(DEP - 1));
    endtask

    // Gradient clear sweep; optional update pulse mid-sweep must be ignored.
    task automatic run_zero(input string nm, input bit poke_update);
        int w0;
        w0 = wv_writes;
        @(negedge clk);
        zero_grad = 1'b1;
        @(posedge clk);
        #1;
        zero_grad = 1'b0;
        for (int n = 1; n <= DEP + 1; n++) begin
            if (poke_update && n == 3) update = 1'b1;
            @(posedge clk);
            #1;
            update = 1'b0;
            chk({nm, " grad_load"}, 128'(grad_load), 128'(n <= DEP));
            if (n <= DEP) begin
                chk({nm, " waddr"}, 128'(waddr), 128'(n - 1));
                chk({nm, " grad_wdata"}, 128'(grad_wdata), 128'd0);
            end
            chk({nm, " w_load"}, 128'(w_load | v_load), 128'd0);
            chk({nm, " valid_zero"}, 128'(valid_zero_grad), 128'(n == DEP + 1));
            chk({nm, " valid_update"}, 128'(valid_update), 128'd0);
        end
        chk({nm, " no wv writes"}, 128'(wv_writes - w0), 128'd0);
        for (int a = 0; a < DEP; a++) chk({nm, " g cleared"}, 128'(g_mem[a]), 128'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{16'h0100, 16'h0080, 32'h00000200, 16'h0050, 16'h0150};
        vt[1] = '{16'h7FF0, 16'h0040, 32'hFFFFFC00, 16'h0078, 16'h7FFF};
        vt[2] = '{16'h8010, 16'hFF80, 32'h00000400, 16'hFF50, 16'h8000};
        vt[3] = '{16'h0000, 16'h0000, 32'h00000000, 16'h0000, 16'h0000};
        vt[4] = '{16'h0005, 16'hFFFF, 32'h0000000F, 16'h0000, 16'h0005};
        vt[5] = '{16'h7FFF, 16'h0000, 32'hFFFFFFFF, 16'h0001, 16'h7FFF};
        vt[6] = '{16'h0000, 16'h0000, 32'h80000000, 16'h7FFF, 16'h7FFF};
        vt[7] = '{16'h1234, 16'h0000, 32'h7FFFFFFF, 16'h8000, 16'h9234};
        vt[8] = '{16'h0400, 16'h0123, 32'hFFFFFFE0, 16'h0101, 16'h0501};
        vt[9] = '{16'h0010, 16'hFFF7, 32'h00000011, 16'hFFF8, 16'h0008};

        rst_n = 1'b0;
        update = 1'b0;
        zero_grad = 1'b0;
        fill_rams();
        #23;
        chk_idle_outputs("reset");
        chk("reset raddr", 128'(raddr), 128'd0);
        chk("reset waddr", 128'(waddr), 128'd0);
        chk("reset valids", 128'({valid_update, valid_zero_grad}), 128'd0);
        chk("reset wdata", 128'({w_wdata, v_wdata}), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Arithmetic sweep over the vector table.
        run_update("upd1");
        begin
            int unsigned k;
            for (int a = 0; a < DEP; a++) begin
                for (int i = 0; i < DN; i++) begin
                    k = (a + i) % NV;
                    chk($sformatf("vec%0d v", k), 128'(v_mem[a][i*DW +: DW]), 128'(vt[k].ev));
                    chk($sformatf("vec%0d w", k), 128'(w_mem[a][i*DW +: DW]), 128'(vt[k].ew));
                    chk($sformatf("vec%0d g kept", k), 128'(g_mem[a][i*GW +: GW]), 128'(vt[k].g));
                end
            end
        end

        // Plain gradient clear from DONE_U.
        run_zero("zero1", 1'b0);

        // Update pulse during ZERO is ignored.
        fill_rams();
        run_zero("zero_poke", 1'b1);

        // update + zero_grad together: UPD first, then ZERO from DONE_U.
        fill_rams();
        @(negedge clk);
        update = 1'b1;
        zero_grad = 1'b1;
        @(posedge clk);
        #1;
        update = 1'b0;
        for (int n = 1; n <= 2 * DEP + 5; n++) begin
            @(posedge clk);
            #1;
            if (n <= DEP + 3) begin
                chk("both grad_load in upd", 128'(grad_load), 128'd0);
                chk("both valid_update", 128'(valid_update), 128'(n == DEP + 3));
            end else begin
                chk("both valid_update dropped", 128'(valid_update), 128'd0);
                chk("both wv load in zero", 128'(w_load | v_load), 128'd0);
                chk("both grad_load", 128'(grad_load), 128'((n >= DEP + 5) && (n <= 2 * DEP + 4)));
                if (n == DEP + 5) begin
                    chk("both zero waddr0", 128'(waddr), 128'd0);
                    zero_grad = 1'b0;
                end
            end
            chk("both valid_zero", 128'(valid_zero_grad), 128'(n == 2 * DEP + 5));
        end
        for (int a = 0; a < DEP; a++) chk("both w updated", 128'(w_mem[a][DW-1:0]), 128'(vt[a % NV].ew));

        // Reset while writing word 5 of an update sweep.
        fill_rams();
        @(negedge clk);
        update = 1'b1;
        @(posedge clk);
        #1;
        update = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("rst mid w_load", 128'(w_load), 128'd1);
        chk("rst mid waddr", 128'(waddr), 128'd5);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("rst async");
        chk("rst async raddr", 128'(raddr), 128'd0);
        begin
            int w0;
            w0 = wv_writes;
            @(negedge clk);
            rst_n = 1'b1;
            repeat (6) begin
                @(posedge clk);
                #1;
                chk_idle_outputs("post rst");
                chk("post rst valids", 128'({valid_update, valid_zero_grad}), 128'd0);
            end
            chk("post rst no writes", 128'(wv_writes - w0), 128'd0);
        end

        // Sweep from IDLE after the abort behaves normally.
        run_update("upd2");
        chk("no load overlap", 128'(overlap), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dense_param_updater.md
# dense_param_updater

Parametrised momentum-SGD sequencer for dense-layer parameter RAMs. On `update` it sweeps every parameter word, reading weight, velocity and gradient RAMs and writing back updated weight and velocity. On `zero_grad` it clears the gradient RAM. It sits beside `dense_forward`/`dense_backward` inside the dense layer and drives the `valid_update`/`valid_zero_grad` handshakes.

## Interface
- `ADDR_WIDTH`, 10, RAM address width.
- `DATA_N`, 8, lanes per RAM word.
- `DEPTH`, `` `HID_DIM*`CHAR_NUM/DATA_N ``, words swept; 1..2^ADDR_WIDTH.
- `DATA_WIDTH`, `` `N_LEN ``, signed weight/velocity lane width.
- `GRAD_WIDTH`, `` `N_LEN_W ``, signed gradient lane width; same fractional bits as weight.
- `MOM_SHIFT`, 3, momentum decay shift (momentum = 1 - 2^-MOM_SHIFT).
- `LR_SHIFT`, 4, learning-rate shift (lr = 2^-LR_SHIFT).
- `clk` in 1: clock; all logic on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `update` in 1: start an update sweep; level or pulse, sampled when idle.
- `zero_grad` in 1: start a gradient-clear sweep; sampled when idle.
- `valid_update` out 1: update sweep complete.
- `valid_zero_grad` out 1: clear sweep complete.
- `raddr` out ADDR_WIDTH: shared read address for w/v/grad RAMs.
- `w_rdata`, `v_rdata` in DATA_N*DATA_WIDTH: read data, 1-cycle RAM latency.
- `grad_rdata` in DATA_N*GRAD_WIDTH: gradient read data, 1-cycle latency.
- `waddr` out ADDR_WIDTH: shared write address.
- `w_load`, `v_load`, `grad_load` out 1: write enables.
- `w_wdata`, `v_wdata` out DATA_N*DATA_WIDTH; `grad_wdata` out DATA_N*GRAD_WIDTH.

## Operation
- FSM states: IDLE, UPD, ZERO, DONE_U, DONE_Z.
- IDLE: `update`=1 -> UPD. Otherwise `zero_grad`=1 -> ZERO. Both high: `update` wins; `zero_grad` stays pending if still held afterwards.
- Start requests in UPD/ZERO are ignored. In DONE_x a new request restarts immediately and clears both valids.
- UPD: counter 0..DEPTH-1 drives `raddr`. Data returns next cycle, lanes are computed and registered, and the write follows one cycle later with `waddr` = read address. After the last write -> DONE_U.
- ZERO: `grad_load`=1 and `grad_wdata`=0 for `waddr` 0..DEPTH-1, one per cycle, no reads. Then -> DONE_Z.
- DONE_U holds `valid_update`=1 and DONE_Z holds `valid_zero_grad`=1 until the next accepted start.
- Lane i (little-endian slice i) arithmetic, in GRAD_WIDTH+2 bits, with arithmetic (floor) shifts:
  - v' = v - (v>>>MOM_SHIFT) - (g>>>LR_SHIFT), saturated to DATA_WIDTH.
  - w' = w + v'_sat, saturated to DATA_WIDTH.
  - Saturation limits are 0x7FFF / 0x8000 for 16 bits.
- `grad_load` is never asserted in UPD. `w_load`/`v_load` are never asserted in ZERO.

## Timing
- Reset: state IDLE. All outputs 0: valids, loads, addresses, wdata.
- Update: start sampled at edge 0. `raddr`=k in cycle k+1, write of k in cycle k+3. `valid_update` rises at edge DEPTH+3. Throughput is 1 word/cycle.
- Zero: `grad_load` high cycles 1..DEPTH. `valid_zero_grad` rises at edge DEPTH+1.
- `raddr` holds its last value while idle. Writes occur only with load=1.
- The counter terminates at DEPTH-1 and never wraps. DEPTH=1 works.
- Reset asserted mid-sweep aborts immediately: loads drop asynchronously and no further writes occur. A partially updated RAM is acceptable.

## Structure
- `MOM_SHIFT`/`LR_SHIFT` defaults come from `consts_train.vh` (`` `MOM_SHIFT ``, `` `LR_SHIFT ``), next to `` `N_LEN ``/`` `N_LEN_W ``.
- Sub-module `dense_optim_lane`: combinational per-lane v'/w' arithmetic with saturation. It is instantiated DATA_N times via generate.
- Top level holds the FSM, counter, 2-stage address pipeline and output registers.

## Test plan
- Reset mid-UPD at word 5 -> all loads 0 instantly; after release, state IDLE, valids 0.
- Update, DATA_WIDTH=16, w=0x0100, v=0x0080, g=0x00000200 -> v'=0x0050, w'=0x0150 at every address. `valid_update` rises DEPTH+3 cycles after start.
- Saturation case: w=0x7FF0, v=0x0040, g=0xFFFFFC00 -> v'=0x0078, w'=0x7FFF. Negative case: w=0x8010, v=0xFF80, g=0x00000400 -> v'=0xFF50, w'=0x8000.
- `zero_grad` alone -> `grad_load` for exactly DEPTH cycles, addresses 0..DEPTH-1, data 0; w/v loads stay 0; `valid_zero_grad` follows.
- `update` and `zero_grad` in the same cycle -> UPD runs first. With `zero_grad` held, ZERO starts from DONE_U and `valid_update` drops.
- Pulse `update` during ZERO -> ignored; no w/v writes; only `valid_zero_grad` asserts.
